// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg -- shared types and defaults for the IF/MA memory port arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int ARB_AW   = 7;
  localparam int ARB_DW   = 32;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_sat_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_sat_cnt -- saturating event counter, async active-low reset.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arb_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter -- shares one BRAM port between IF and MA requesters.
// Rev 1.0; define ARB_PERF_CNT_EN to build the saturating stall counters.
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = ARB_AW,
  parameter int DW           = ARB_DW,
  parameter int MA_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ma_req,
  input  logic          ma_we,
  input  logic [AW-1:0] ma_addr,
  input  logic [DW-1:0] ma_wdata,
  output logic          ma_gnt,
  output logic          ma_rvalid,
  output logic [DW-1:0] ma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [31:0]   if_stall_cnt,
  output logic [31:0]   ma_stall_cnt
);

  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(MA_BURST_MAX);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  owner_t              owner_q;
  owner_t              owner_d;

  logic w_if_win;
  logic w_if_gnt;
  logic w_ma_gnt;

  // MA has priority under contention until it has held the port for
  // BURST_LIMIT consecutive contended grants; then IF gets one slot.
  always_comb begin
    w_if_win = if_req & (~ma_req | (streak_q == BURST_LIMIT));
    w_if_gnt = rst & w_if_win;
    w_ma_gnt = rst & ma_req & ~w_if_win;
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || w_if_gnt) begin
      streak_d = '0;
    end else if (w_ma_gnt && (streak_q != BURST_LIMIT)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // Stores produce no response, so they leave the owner idle.
  always_comb begin
    owner_d = OWN_NONE;
    if (w_if_gnt) begin
      owner_d = OWN_IF;
    end else if (w_ma_gnt && !ma_we) begin
      owner_d = OWN_MA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
      mem_din  = ma_wdata;
    end else if (w_ma_gnt) begin
      mem_addr = ma_addr;
      mem_din  = ma_wdata;
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ma_gnt    = w_ma_gnt;
  assign mem_en    = w_if_gnt | w_ma_gnt;
  assign mem_we    = w_ma_gnt & ma_we;
  assign if_rvalid = (owner_q == OWN_IF);
  assign ma_rvalid = (owner_q == OWN_MA);
  assign if_rdata  = mem_dout;
  assign ma_rdata  = mem_dout;

`ifdef ARB_PERF_CNT_EN
  mem_arb_sat_cnt #(
    .W(32)
  ) u_if_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(if_req & ~w_if_gnt),
    .cnt_o(if_stall_cnt)
  );

  mem_arb_sat_cnt #(
    .W(32)
  ) u_ma_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(ma_req & ~w_ma_gnt),
    .cnt_o(ma_stall_cnt)
  );
`else
  assign if_stall_cnt = 32'd0;
  assign ma_stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter -- directed scoreboard bench for mem_port_arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ma_req;
  logic          ma_we;
  logic [AW-1:0] ma_addr;
  logic [DW-1:0] ma_wdata;
  logic          ma_gnt;
  logic          ma_rvalid;
  logic [DW-1:0] ma_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [31:0]   if_stall_cnt;
  logic [31:0]   ma_stall_cnt;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .MA_BURST_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .ma_req      (ma_req),
    .ma_we       (ma_we),
    .ma_addr     (ma_addr),
    .ma_wdata    (ma_wdata),
    .ma_gnt      (ma_gnt),
    .ma_rvalid   (ma_rvalid),
    .ma_rdata    (ma_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .if_stall_cnt(if_stall_cnt),
    .ma_stall_cnt(ma_stall_cnt)
  );

  always #5 clk = ~clk;

  // Write-first single-port BRAM with registered output.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_din;
        mem_dout       <= mem_din;
      end else begin
        mem_dout <= bram[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic          iv;
    logic          mv;
    logic [DW-1:0] d;
  } rsp_t;

  rsp_t          exp_q [$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive, check grant/port mid-cycle, then check the
  // response registered by the following edge against the scoreboard.
  task automatic step(input logic ir, input logic [AW-1:0] ia,
                      input logic mr, input logic mw, input logic [AW-1:0] ma,
                      input logic [DW-1:0] md, input logic eig, input logic emg,
                      input string tag);
    rsp_t r;
    logic [AW-1:0] ea;
    if_req = ir; if_addr = ia;
    ma_req = mr; ma_we = mw; ma_addr = ma; ma_wdata = md;
    @(negedge clk);
    ea = eig ? ia : (emg ? ma : '0);
    chk({tag, ".if_gnt"},   32'(if_gnt),   32'(eig));
    chk({tag, ".ma_gnt"},   32'(ma_gnt),   32'(emg));
    chk({tag, ".mem_en"},   32'(mem_en),   32'(eig | emg));
    chk({tag, ".mem_we"},   32'(mem_we),   32'(emg & mw));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
    r = '0;
    if (eig) r = {1'b1, 1'b0, ref_mem[ia]};
    else if (emg && !mw) r = {1'b0, 1'b1, ref_mem[ma]};
    if (emg && mw) ref_mem[ma] = md;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      r = exp_q.pop_front();
      chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(r.iv));
      chk({tag, ".ma_rvalid"}, 32'(ma_rvalid), 32'(r.mv));
      if (r.iv) chk({tag, ".if_rdata"}, if_rdata, r.d);
      if (r.mv) chk({tag, ".ma_rdata"}, ma_rdata, r.d);
    end
  endtask

  initial begin
    logic [31:0] exp_if_cnt;
    logic [31:0] exp_ma_cnt;
    for (int i = 0; i < (1 << AW); i++) begin
      bram[i]    = 32'(i + 100);
      ref_mem[i] = 32'(i + 100);
    end

    // Reset state with both requesters asking.
    rst = 1'b0;
    if_req = 1'b1; if_addr = 7'd1;
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 7'd2; ma_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.if_gnt", 32'(if_gnt), 32'd0);
    chk("rst.ma_gnt", 32'(ma_gnt), 32'd0);
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    chk("rst.if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst.ma_rvalid", 32'(ma_rvalid), 32'd0);
    chk("rst.if_stall_cnt", if_stall_cnt, 32'd0);
    chk("rst.ma_stall_cnt", ma_stall_cnt, 32'd0);
    if_req = 1'b0; ma_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // IF-only stream.
    for (int i = 0; i < 3; i++) step(1'b1, 7'(i), 1'b0, 1'b0, 7'd0, '0, 1'b1, 1'b0, "if_stream");

    // Store then load at the same address.
    step(1'b0, 7'd0, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0, 1'b1, "store5");
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd5, '0,           1'b0, 1'b1, "load5");

    // Response routing: IF read then MA load.
    step(1'b1, 7'd3, 1'b0, 1'b0, 7'd0, '0, 1'b1, 1'b0, "route_if3");
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd7, '0, 1'b0, 1'b1, "route_ma7");

    // Contention fairness.
    for (int i = 0; i < 10; i++)
      step(1'b1, 7'd3, 1'b1, 1'b0, 7'd7, '0, (i == 4 || i == 9), !(i == 4 || i == 9), "contend");

    // A cycle with if_req low restarts the MA streak.
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd8, '0, 1'b0, 1'b1, "streak_clr_idle");
    step(1'b1, 7'd4, 1'b1, 1'b0, 7'd8, '0, 1'b0, 1'b1, "pre_clr0");
    step(1'b1, 7'd4, 1'b1, 1'b0, 7'd8, '0, 1'b0, 1'b1, "pre_clr1");
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd9, '0, 1'b0, 1'b1, "streak_clr_drop");
    for (int i = 0; i < 5; i++)
      step(1'b1, 7'd4, 1'b1, 1'b0, 7'd9, '0, (i == 4), (i != 4), "after_clr");

    // Two contended MA grants build a streak, then reset lands mid-read.
    step(1'b1, 7'd6, 1'b1, 1'b0, 7'd7, '0, 1'b0, 1'b1, "pre_rst0");
    step(1'b1, 7'd6, 1'b1, 1'b0, 7'd7, '0, 1'b0, 1'b1, "pre_rst1");
    @(negedge clk);
    chk("midrst.ma_gnt_before", 32'(ma_gnt), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst.if_gnt", 32'(if_gnt), 32'd0);
    chk("midrst.ma_gnt", 32'(ma_gnt), 32'd0);
    chk("midrst.mem_en", 32'(mem_en), 32'd0);
    chk("midrst.mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst.if_rvalid", 32'(if_rvalid), 32'd0);
    chk("midrst.ma_rvalid", 32'(ma_rvalid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Streak restarts from zero; stall counters see three contended cycles.
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'd6, 1'b1, 1'b0, 7'd7, '0, 1'b0, 1'b1, "post_rst");
`ifdef ARB_PERF_CNT_EN
    exp_if_cnt = 32'd3;
    exp_ma_cnt = 32'd0;
`else
    exp_if_cnt = 32'd0;
    exp_ma_cnt = 32'd0;
`endif
    chk("perf.if_stall_cnt", if_stall_cnt, exp_if_cnt);
    chk("perf.ma_stall_cnt", ma_stall_cnt, exp_ma_cnt);
    step(1'b1, 7'd6, 1'b1, 1'b0, 7'd7, '0, 1'b0, 1'b1, "post_rst3");
    step(1'b1, 7'd6, 1'b1, 1'b0, 7'd7, '0, 1'b1, 1'b0, "post_rst4");

    if_req = 1'b0; ma_req = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 128x32 synchronous BRAM between the instruction-fetch requester and the memory-access (load/store) requester of the 5-stage pipeline.
- Drives the BRAM port and grants one requester per cycle.
- Routes 1-cycle-latency read data back to the requester that issued the read, tagged with a valid strobe.
- A denied grant is the stall indication consumed by the pipeline's stop logic.

Parameters:
AW, 7, memory address width (words)
DW, 32, data width
MA_BURST_MAX, 4, max consecutive contended MA grants before IF is forced one slot (range 1..15)

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
if_req  input  1  IF read request
if_addr  input  AW  IF word address
if_gnt  output  1  IF request accepted this cycle
if_rvalid  output  1  if_rdata valid (one cycle after if_gnt)
if_rdata  output  DW  IF read data
ma_req  input  1  MA request
ma_we  input  1  1 = store, 0 = load
ma_addr  input  AW  MA word address
ma_wdata  input  DW  store data
ma_gnt  output  1  MA request accepted this cycle
ma_rvalid  output  1  ma_rdata valid (one cycle after a load grant)
ma_rdata  output  DW  MA read data
mem_en  output  1  BRAM enable
mem_we  output  1  BRAM write enable
mem_addr  output  AW  BRAM address
mem_din  output  DW  BRAM write data
mem_dout  input  DW  BRAM read data (registered inside BRAM, 1-cycle latency)
if_stall_cnt  output  32  IF cycles requested but not granted
ma_stall_cnt  output  32  MA cycles requested but not granted

Behaviour:
- Grant is combinational from the current requests and registered state. At most one of if_gnt/ma_gnt is high per cycle.
- Arbitration:
  - Only one requester asserting → it wins.
  - Both asserting → MA wins, unless streak == MA_BURST_MAX, in which case IF wins.
- streak counter (4 bits):
  - Increments on an MA grant while if_req is high.
  - Clears on any IF grant, or on any cycle with if_req low.
  - Never exceeds MA_BURST_MAX.
- BRAM port:
  - Winner's address drives mem_addr; mem_en = if_gnt | ma_gnt.
  - mem_we = ma_gnt & ma_we; mem_din = ma_wdata.
  - With no grant, mem_addr and mem_din hold 0.
- Owner register, updated every clock. States: OWN_NONE, OWN_IF, OWN_MA.
  - Next state is OWN_IF on if_gnt, OWN_MA on ma_gnt with ma_we=0, otherwise OWN_NONE (including stores).
  - if_rvalid = (owner == OWN_IF); ma_rvalid = (owner == OWN_MA).
  - if_rdata and ma_rdata both carry mem_dout; only the flagged one is meaningful.
- Latency:
  - Read: grant in cycle N, data and rvalid in cycle N+1.
  - Store: committed at the edge ending cycle N, no response.
- Requesters hold req and address until granted. A request dropped before its grant is simply not served. The arbiter does not latch ungranted requests.
- Back-to-back grants to the same or different requesters every cycle are legal; throughput is 1 access per cycle.
- Reset (rst low), asynchronous:
  - owner = OWN_NONE, streak = 0, rvalid outputs 0, counters 0.
  - if_gnt, ma_gnt, mem_en and mem_we are forced 0 while rst is low.
  - A read granted in the cycle reset asserts never produces rvalid.
- Same-address store then load in consecutive cycles returns the newly written data (BRAM write-first mode is required).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - if_stall_cnt increments each cycle with if_req & ~if_gnt.
  - ma_stall_cnt increments each cycle with ma_req & ~ma_gnt.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: both ports remain present and are tied to 0; no counter flops are synthesized.

Decomposition:
- Package mem_arb_pkg: owner_t enum (OWN_NONE, OWN_IF, OWN_MA), default AW/DW constants, STREAK_W = 4.
- One sub-module, mem_arb_sat_cnt: a 32-bit saturating counter with an increment input and async active-low reset, instantiated twice under ARB_PERF_CNT_EN.

Test Plan:
- IF-only stream: if_req=1 with addr 0,1,2 on consecutive cycles, BRAM preloaded with mem[i]=i+100 → if_gnt=1 every cycle; if_rvalid with if_rdata = 100, 101, 102 one cycle later each.
- Store then load: ma store addr 5 data 32'hDEADBEEF, next cycle ma load addr 5 → no ma_rvalid after the store; ma_rvalid with 32'hDEADBEEF the cycle after the load grant.
- Contention fairness, MA_BURST_MAX=4: if_req and ma_req both held high for 10 cycles → grant pattern MA,MA,MA,MA,IF,MA,MA,MA,MA,IF.
- Response routing: IF read addr 3 in cycle N, MA load addr 7 in cycle N+1 → cycle N+1 has only if_rvalid=1 (mem[3]); cycle N+2 has only ma_rvalid=1 (mem[7]).
- Reset mid-read: IF granted in cycle N, rst driven low mid-cycle N → if_rvalid stays 0; all grants 0 while rst low; streak and owner restart from 0/OWN_NONE after release.
- ARB_PERF_CNT_EN defined: 3 cycles of MA-only traffic with if_req held high (MA_BURST_MAX=4) → if_stall_cnt=3, ma_stall_cnt=0. Macro undefined → both counters read 0.
